// File: rtl/juego_pkg.sv
// Shared types and display constants for the hero game's obstacle path.
package juego_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HIT  = 2'd2
  } estado_t;

  // Segment bit index within one 7-segment digit {g,f,e,d,c,b,a}
  localparam int unsigned SEG_A   = 0;
  localparam int unsigned SEG_G   = 6;
  localparam int unsigned SEG_D   = 3;
  localparam int unsigned DIGIT_W = 7;

  // One-hot lane for a new obstacle; code 2'b11 spawns nothing
  function automatic logic [2:0] spawn_col(input logic [7:0] lfsr_state);
    logic [2:0] col;
    col = '0;
    if (lfsr_state[1:0] != 2'b11) col[lfsr_state[1:0]] = 1'b1;
    return col;
  endfunction

  // Lane 0 lights seg a, lane 1 seg g, lane 2 seg d
  function automatic logic [DIGIT_W-1:0] lane_to_seg(input logic [2:0] col);
    logic [DIGIT_W-1:0] seg;
    seg        = '0;
    seg[SEG_A] = col[0];
    seg[SEG_G] = col[1];
    seg[SEG_D] = col[2];
    return seg;
  endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, shifting left with feedback into b0.
module lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic       adv_i,
  output logic [7:0] state_o
);

  logic [7:0] state_q;
  logic       fb;

  assign fb      = state_q[7] ^ state_q[5] ^ state_q[4] ^ state_q[3];
  assign state_o = state_q;

  // Load has priority over advance so a restart always begins from SEED
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= SEED;
    end else if (load_i) begin
      state_q <= SEED;
    end else if (adv_i) begin
      state_q <= {state_q[6:0], fb};
    end
  end

endmodule

// File: rtl/secuenciador_obstaculos.sv
// Obstacle field sequencer: prescaled scroll, LFSR spawning, collision and score.
module secuenciador_obstaculos
  import juego_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 27_000_000,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  heroe,
  output logic [20:0] disp_obs,
  output logic        step,
  output logic        hit,
  output logic [7:0]  score,
  output logic [1:0]  estado
);

  localparam int unsigned PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

  estado_t          estado_q, estado_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [2:0][2:0]  obs_q, obs_d;      // [position][lane], position 0 nearest the hero
  logic [7:0]       score_q, score_d;
  logic             step_q, step_d;
  logic             hit_q, hit_d;
  logic [7:0]       lfsr_state;

  logic step_cycle;
  logic collide;
  logic advance;

  assign step_cycle = (estado_q == RUN) && (presc_q == PRESC_MAX);
  assign collide    = |(obs_q[0] & heroe);
  // start wins over a coinciding step, so neither shift nor collision happens then
  assign advance    = step_cycle && !start && !collide;

  lfsr8 #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .clk_i  (clk),
    .rst_i  (rst),
    .load_i (start),
    .adv_i  (advance),
    .state_o(lfsr_state)
  );

  // Next-state logic for FSM, prescaler, grid and score
  always_comb begin
    estado_d = estado_q;
    presc_d  = presc_q;
    obs_d    = obs_q;
    score_d  = score_q;
    step_d   = 1'b0;
    unique case (estado_q)
      IDLE: begin
        presc_d = '0;
        obs_d   = '0;
        score_d = '0;
        if (start) estado_d = RUN;
      end
      RUN: begin
        if (start) begin
          presc_d = '0;
          obs_d   = '0;
          score_d = '0;
        end else if (step_cycle) begin
          step_d  = 1'b1;
          presc_d = '0;
          if (collide) begin
            estado_d = HIT;
          end else begin
            if ((obs_q[0] != 3'b000) && (score_q != 8'hFF)) score_d = score_q + 8'd1;
            obs_d[0] = obs_q[1];
            obs_d[1] = obs_q[2];
            obs_d[2] = spawn_col(lfsr_state);
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      HIT: begin
        if (start) begin
          presc_d  = '0;
          obs_d    = '0;
          score_d  = '0;
          estado_d = RUN;
        end
      end
      default: begin
        estado_d = IDLE;
        presc_d  = '0;
        obs_d    = '0;
        score_d  = '0;
      end
    endcase
    hit_d = (estado_d == HIT);
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q <= IDLE;
      presc_q  <= '0;
      obs_q    <= '0;
      score_q  <= '0;
      step_q   <= 1'b0;
      hit_q    <= 1'b0;
    end else begin
      estado_q <= estado_d;
      presc_q  <= presc_d;
      obs_q    <= obs_d;
      score_q  <= score_d;
      step_q   <= step_d;
      hit_q    <= hit_d;
    end
  end

  assign disp_obs = {lane_to_seg(obs_q[2]), lane_to_seg(obs_q[1]), lane_to_seg(obs_q[0])};
  assign step     = step_q;
  assign hit      = hit_q;
  assign score    = score_q;
  assign estado   = estado_q;

endmodule

// File: doc/secuenciador_obstaculos.md
# secuenciador_obstaculos

Sequences the hero game's obstacle field. A prescaled step tick scrolls a 3-position × 3-lane obstacle grid toward the hero, and an 8-bit LFSR spawns new obstacles at the far end. The block checks each exiting column against the hero lane, keeps the score, and drives the 21-bit obstacle display bus `disp_obs` consumed by the 7-segment driver. It sits between the top-level game FSM (which issues `start` and reads `hit`) and the display path.

## Interface
- `CLK_DIV`, 27_000_000: clk cycles per scroll step (≥2).
- `LFSR_SEED`, 8'hA5: LFSR load value on reset/start; must be nonzero.
- `clk` input 1: system clock.
- `rst` input 1: reset, asynchronous, active-high.
- `start` input 1: single-cycle pulse; clears state and begins a round.
- `heroe` input 3: hero lane, one-hot (bit0 top, bit1 middle, bit2 bottom); 0 means the hero is off-field.
- `disp_obs` output 21: obstacle segments; digit2 = [20:14], digit1 = [13:7], digit0 = [6:0]; within a digit {g,f,e,d,c,b,a}, active-high.
- `step` output 1: one-cycle pulse on each scroll step.
- `hit` output 1: high while in HIT.
- `score` output 8: columns cleared, saturating at 255.
- `estado` output 2: IDLE = 0, RUN = 1, HIT = 2.

## Operation
- Grid `obs[p][l]`: p = 2 (far) .. 0 (near the hero); l = lane 0..2.
- Display mapping for digit p: lane0 → seg a (bit 7p+0), lane1 → seg g (bit 7p+6), lane2 → seg d (bit 7p+3). All other segment bits are 0.
- IDLE:
  - grid, score and prescaler are held at 0;
  - `start` → reload LFSR with `LFSR_SEED`, go to RUN.
- RUN: the prescaler counts 0..CLK_DIV-1. At count CLK_DIV-1 (the step cycle) the block does the following, all in one cycle:
  - Collision: if `(obs[0] & heroe) != 0` → go to HIT; the grid, score and LFSR do not update on this step.
  - Otherwise:
    - `score += (obs[0] != 0)`, saturating at 255.
    - `obs[0] <= obs[1]`, `obs[1] <= obs[2]`.
    - `obs[2] <=` one-hot lane `lfsr[1:0]` if `lfsr[1:0] != 2'b11`, else 0.
    - LFSR advances once: Fibonacci, taps x^8+x^6+x^5+x^4+1, shift left, feedback = b7^b5^b4^b3 into b0.
- HIT:
  - grid and score are frozen;
  - `start` → clear grid, score and prescaler, reload LFSR, go to RUN.
- `start` during RUN: same as the HIT restart (clear, reload, stay in RUN).
- `heroe` with more than one bit set: any overlap is a collision. `heroe` = 0 never collides.
- `rst` at any time: immediately forces all reset values.

## Timing
- Reset values:
  - `disp_obs` = 0, `step` = 0, `hit` = 0, `score` = 0, `estado` = IDLE;
  - LFSR = `LFSR_SEED`, prescaler = 0.
- All outputs are registered.
- `disp_obs` and `score` reflect a step one cycle after the step cycle, together with the `step` pulse.
- `hit` and `estado` = HIT assert one cycle after the colliding step cycle.
- The first step occurs CLK_DIV cycles after the cycle in which `start` is sampled.
- `start` coinciding with a step cycle: `start` wins; no shift, no collision check.
- `heroe` is sampled only on the step cycle; no synchronizer inside the block (the caller provides synchronized input).

## Structure
- Package `juego_pkg`:
  - `estado_t` enum (IDLE, RUN, HIT);
  - lane-to-segment bit constants (SEG_A = 0, SEG_G = 6, SEG_D = 3);
  - `DIGIT_W` = 7.
- Sub-module `lfsr8`: load/advance enable, 8-bit state output.
- Prescaler, grid, score and FSM live in `secuenciador_obstaculos`.

## Test plan
All scenarios use `CLK_DIV` = 4 and `LFSR_SEED` = 8'hA5.
- Reset released, no `start` for 20 cycles → `estado` = 0, `disp_obs` = 0, `step` never pulses.
- `start`, `heroe` = 3'b001 → first `step` 4 cycles later; `lfsr[1:0]` = 01 spawns lane1, so `disp_obs` = 21'h100000; LFSR becomes 8'h4A.
- Continue with `heroe` = 0 for 10 steps → the spawned obstacle reaches digit0 on step 3 (`disp_obs`[6] = 1); `score` increments only on steps whose exiting column is nonzero, checked against a reference model.
- Move `heroe` onto the lane of the obstacle in `obs[0]` before the next step cycle → `hit` = 1 and `estado` = 2 one cycle after that step; `disp_obs` stays frozen for 12 further cycles.
- Force `score` to 255 via a long run with `heroe` = 0 → stays at 255; `start` in HIT → `score` = 0, `disp_obs` = 0, `estado` = 1.
- Assert `rst` in the middle of a RUN step cycle → all outputs reach reset values in the same cycle; `start` pulsed on the same cycle as a step → no shift, prescaler restarts at 0.
